// File: rtl/load_align_unit_pkg.sv
// Load-return shared definitions: funct3 codes, FSM states, size/sign decode.
// Latency: none (types and a pure function only).
// Backpressure: not applicable.
package ld_pkg;

    localparam logic [2:0] FNC_LB  = 3'b000;
    localparam logic [2:0] FNC_LH  = 3'b001;
    localparam logic [2:0] FNC_LW  = 3'b010;
    localparam logic [2:0] FNC_LD  = 3'b011;
    localparam logic [2:0] FNC_LBU = 3'b100;
    localparam logic [2:0] FNC_LHU = 3'b101;
    localparam logic [2:0] FNC_LWU = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT0 = 2'd1,
        ST_WAIT1 = 2'd2,
        ST_RESP  = 2'd3
    } ld_state_e;

    // Decoded load shape; size is in bytes (1/2/4/8), zero when illegal.
    typedef struct packed {
        logic       legal;
        logic [3:0] size;
        logic       sign;
    } ld_dec_t;

    // LD and LWU exist only on a 64-bit datapath.
    function automatic ld_dec_t ld_decode(input logic [2:0] funct3, input int unsigned xlen);
        ld_dec_t d;
        d = '0;
        case (funct3)
            FNC_LB:  begin d.legal = 1'b1;           d.size = 4'd1; d.sign = 1'b1; end
            FNC_LH:  begin d.legal = 1'b1;           d.size = 4'd2; d.sign = 1'b1; end
            FNC_LW:  begin d.legal = 1'b1;           d.size = 4'd4; d.sign = 1'b1; end
            FNC_LD:  begin d.legal = (xlen == 64);   d.size = 4'd8; d.sign = 1'b1; end
            FNC_LBU: begin d.legal = 1'b1;           d.size = 4'd1; d.sign = 1'b0; end
            FNC_LHU: begin d.legal = 1'b1;           d.size = 4'd2; d.sign = 1'b0; end
            FNC_LWU: begin d.legal = (xlen == 64);   d.size = 4'd4; d.sign = 1'b0; end
            default: d = '0;
        endcase
        if (!d.legal) begin
            d = '0;
        end
        return d;
    endfunction

endpackage

// File: rtl/load_align_unit_extract.sv
// Field extractor: shifts a two-word little-endian window and sign/zero-extends the field.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
module ld_extract #(
    parameter int XLEN = 32,
    localparam int OFFW = $clog2(XLEN / 8)
) (
    input  logic [2*XLEN-1:0] window_i,
    input  logic [OFFW-1:0]   off_i,
    input  logic [3:0]        size_i,
    input  logic              sign_i,
    output logic [XLEN-1:0]   data_o
);

    logic [XLEN-1:0] field;
    logic [7:0]      fb;
    logic [15:0]     fh;
    logic [31:0]     fw;

    // Byte offset selects the field start; anything past one word is never needed.
    assign field = XLEN'(window_i >> {off_i, 3'b000});
    assign fb    = field[7:0];
    assign fh    = field[15:0];
    assign fw    = field[31:0];

    // Truncate to the access size, then extend to the full word.
    always_comb begin
        data_o = '0;
        case (size_i)
            4'd1:    data_o = sign_i ? XLEN'($signed(fb)) : XLEN'(fb);
            4'd2:    data_o = sign_i ? XLEN'($signed(fh)) : XLEN'(fh);
            4'd4:    data_o = sign_i ? XLEN'($signed(fw)) : XLEN'(fw);
            4'd8:    data_o = field;
            default: data_o = '0;
        endcase
    end

endmodule

// File: rtl/load_align_unit.sv
// Memory-stage load unit: one request at a time, 1 or 2 word reads, aligned/extended result.
// Latency: response 2 cycles after accept (3 if word-spanning, 1 on fault).
// Backpressure: result held in RESP until rsp_ready; req_ready only in IDLE.
module load_align_unit
    import ld_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter bit MISALIGN_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    output logic            mem_ren,
    output logic [XLEN-1:0] mem_addr,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_data,
    output logic            rsp_fault
);

    localparam int WB   = XLEN / 8;
    localparam int OFFW = $clog2(WB);

    ld_state_e       state_q;
    logic [OFFW-1:0] off_q;
    logic [3:0]      size_q;
    logic            sign_q;
    logic            span_q;
    logic [XLEN-1:0] base_q;
    logic [XLEN-1:0] lo_q;
    logic            rsp_valid_q;
    logic [XLEN-1:0] rsp_data_q;
    logic            rsp_fault_q;

    ld_dec_t         dec;
    logic [OFFW-1:0] req_off;
    logic [XLEN-1:0] req_base;
    logic            req_misaligned;
    logic            req_spanning;
    logic            req_fault;
    logic [2*XLEN-1:0] window;
    logic [XLEN-1:0] ext_data;

    // Request decode is only meaningful while IDLE; it feeds the accept decision.
    assign dec            = ld_decode(req_funct3, XLEN);
    assign req_off        = req_addr[OFFW-1:0];
    assign req_base       = {req_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
    assign req_misaligned = (({{(4-OFFW){1'b0}}, req_off} & (dec.size - 4'd1)) != 4'd0);
    assign req_spanning   = ((5'(req_off) + 5'(dec.size)) > 5'(WB));
    assign req_fault      = !dec.legal || (req_misaligned && (MISALIGN_EN == 1'b0));

    assign req_ready = (state_q == ST_IDLE) && !rst;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_fault = rsp_fault_q;

    // Reads go out in the accepting IDLE cycle and in WAIT0 of a spanning access only.
    always_comb begin
        mem_ren  = 1'b0;
        mem_addr = '0;
        if (!rst) begin
            if (state_q == ST_IDLE && req_valid && !req_fault) begin
                mem_ren  = 1'b1;
                mem_addr = req_base;
            end else if (state_q == ST_WAIT0 && span_q) begin
                mem_ren  = 1'b1;
                mem_addr = base_q + XLEN'(WB);
            end
        end
    end

    // In WAIT1 the high word arrives live on mem_rdata; otherwise the field lies in one word.
    always_comb begin
        window = {{XLEN{1'b0}}, mem_rdata};
        if (state_q == ST_WAIT1) begin
            window = {mem_rdata, lo_q};
        end
    end

    ld_extract #(
        .XLEN(XLEN)
    ) u_extract (
        .window_i (window),
        .off_i    (off_q),
        .size_i   (size_q),
        .sign_i   (sign_q),
        .data_o   (ext_data)
    );

    // Control FSM with request latch, low-word capture and registered response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            off_q       <= '0;
            size_q      <= '0;
            sign_q      <= 1'b0;
            span_q      <= 1'b0;
            base_q      <= '0;
            lo_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_fault_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        if (req_fault) begin
                            rsp_valid_q <= 1'b1;
                            rsp_data_q  <= '0;
                            rsp_fault_q <= 1'b1;
                            state_q     <= ST_RESP;
                        end else begin
                            off_q   <= req_off;
                            size_q  <= dec.size;
                            sign_q  <= dec.sign;
                            span_q  <= req_spanning;
                            base_q  <= req_base;
                            state_q <= ST_WAIT0;
                        end
                    end
                end
                ST_WAIT0: begin
                    lo_q <= mem_rdata;
                    if (span_q) begin
                        state_q <= ST_WAIT1;
                    end else begin
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= ext_data;
                        rsp_fault_q <= 1'b0;
                        state_q     <= ST_RESP;
                    end
                end
                ST_WAIT1: begin
                    rsp_valid_q <= 1'b1;
                    rsp_data_q  <= ext_data;
                    rsp_fault_q <= 1'b0;
                    state_q     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/load_align_unit.md
# load_align_unit

Parametrised load-return unit for the memory stage of the RISC-V pipeline. It accepts one load request at a time, reads one or two memory words, and extracts, sign-extends or zero-extends the addressed field. Beyond fixed per-funct3 selection, it optionally splits word-spanning misaligned loads into two reads, flags illegal or misaligned requests, and uses valid/ready handshakes on both sides.

## Interface
Parameters:
- `XLEN`, default 32: data/word width; legal values are 32 and 64. `WB = XLEN/8` bytes per word.
- `MISALIGN_EN`, default 1: 1 splits spanning accesses into two reads; 0 faults any misaligned access.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  load request present.
- `req_ready`  out  1  unit can accept a request.
- `req_funct3`  in  3  load funct3 (`FNC_LB/LH/LW/LBU/LHU`; plus LD=011 and LWU=110 when XLEN=64).
- `req_addr`  in  XLEN  byte address.
- `mem_ren`  out  1  memory read strobe.
- `mem_addr`  out  XLEN  word-aligned read address (low log2(WB) bits are 0).
- `mem_rdata`  in  XLEN  read data; valid exactly 1 cycle after `mem_ren`.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer takes the result.
- `rsp_data`  out  XLEN  extended load result.
- `rsp_fault`  out  1  illegal funct3, or misaligned access with MISALIGN_EN=0.

## Operation
- Size decode: B=1, H=2, W=4, D=8 bytes. Signed for LB/LH/LW(XLEN=64)/LD; unsigned for LBU/LHU/LWU. When XLEN=32, LW needs no extension.
- Offset `off = req_addr mod WB`. The access is misaligned when `off mod size != 0`, and spanning when `off + size > WB`.
- States: IDLE, WAIT0, WAIT1, RESP.
- IDLE: `req_ready=1`. On `req_valid`:
  - Illegal funct3, or misaligned with MISALIGN_EN=0: latch fault, issue no read, go to RESP.
  - Otherwise: assert `mem_ren` combinationally in the same cycle with `mem_addr` = word base, latch the request, go to WAIT0.
- WAIT0: capture `mem_rdata` as lo.
  - If spanning: assert `mem_ren` with `mem_addr` = base+WB (wraps modulo 2^XLEN), go to WAIT1.
  - Else go to RESP.
- WAIT1: capture `mem_rdata` as hi, go to RESP.
- Extraction: window = {hi, lo} (little-endian). Field = window >> (off*8), truncated to size bytes, then extended to XLEN.
- RESP: `rsp_valid=1`. `rsp_data` and `rsp_fault` are registered and held stable until `rsp_valid && rsp_ready`, then return to IDLE. `req_ready=0` outside IDLE; there is no request overlap.
- Fault response: `rsp_data=0`, `rsp_fault=1`.
- Reset values: state IDLE; `rsp_valid=0`, `rsp_data=0`, `rsp_fault=0`, `mem_ren=0`, `mem_addr=0`. `req_ready=0` while `rst` is high.
- Reset mid-operation (any state): return to IDLE next cycle, drop the pending response, ignore the in-flight `mem_rdata`.

## Timing
- Request accepted at cycle T (`req_valid && req_ready`).
- Non-spanning: read at T, data at T+1, `rsp_valid` at T+2.
- Spanning: reads at T and T+1, `rsp_valid` at T+3.
- Fault: no read; `rsp_valid` at T+1.
- Response leaves on the edge where `rsp_ready=1`. The next request can be accepted in the cycle after the handshake, giving peak throughput of one load per 3 cycles.
- `mem_ren` is asserted only in accepting-IDLE and spanning-WAIT0 cycles, and never while `rst` is high.

## Structure
- Package `ld_pkg`: funct3 constants for LB/LH/LW/LD/LBU/LHU/LWU, the state enum, and size/sign decode function `ld_decode(funct3, xlen)`.
- Sub-module `ld_extract`: combinational 2*XLEN window shift, size mask and sign/zero extension, parametrised by XLEN.
- Top level holds the FSM, request latch and lo/hi registers.

## Test plan
- XLEN=32, LW at 0x100, mem[0x100]=0xDEADBEEF -> one read at 0x100; `rsp_data=0xDEADBEEF` at T+2; `rsp_fault=0`.
- LB and LBU at 0x103, mem[0x100]=0x80AABBCC -> LB gives 0xFFFFFF80, LBU gives 0x00000080.
- MISALIGN_EN=1, LH at 0x103, mem[0x100]=0x11223344, mem[0x104]=0x55667788 -> reads at 0x100 then 0x104; `rsp_data=0xFFFF8811` at T+3.
- MISALIGN_EN=0, LW at 0x102 -> `mem_ren` never asserted; `rsp_fault=1`, `rsp_data=0` at T+1. Also, XLEN=32 with funct3=011 -> fault.
- `rsp_ready` held 0 for 3 cycles in RESP -> `rsp_valid`/`rsp_data` stable; `req_ready=0` ignores a new `req_valid`; accepted after the handshake.
- `rst` pulsed in WAIT1 of a spanning LW -> IDLE next cycle, no `rsp_valid`; `req_ready=1` once `rst` drops; the next LW completes normally.
